timer_irq_gen: RTL

Memory-mapped machine timer peripheral on the SoC bus. It is the interrupt source that drives the core interrupt controller's `int_req` input. A prescaled counter is compared against a programmable compare value. On a match the block sets a sticky pending flag and presents a level interrupt request until software clears it with write-1-to-clear. One-shot and auto-reload (periodic) modes are supported.

---
 rtl/timer_irq_gen_pkg.sv | 30 +++
 rtl/timer_prescaler.sv | 32 +++
 rtl/timer_irq_gen.sv | 129 ++++++++++++
 3 files changed

// File: rtl/timer_irq_gen_pkg.sv
`default_nettype none
// ============================================================================
// timer_irq_gen_pkg : shared register offsets, CTRL bit positions, IRQ indices
// Revision: 1.0
// ============================================================================
package timer_irq_gen_pkg;

  // Register offsets as decoded from addr[3:2]
  localparam logic [1:0] TIMER_CTRL  = 2'd0;
  localparam logic [1:0] TIMER_COUNT = 2'd1;
  localparam logic [1:0] TIMER_CMP   = 2'd2;
  localparam logic [1:0] TIMER_PRE   = 2'd3;

  localparam int CTRL_EN          = 0;
  localparam int CTRL_INT_EN      = 1;
  localparam int CTRL_AUTO_RELOAD = 2;
  localparam int CTRL_PENDING     = 3;

  localparam int          INT_TIMER0 = 0;
  localparam logic [31:0] INT_NONE   = 32'h0;

  typedef struct packed {
    logic pending;
    logic auto_reload;
    logic int_en;
    logic en;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// ============================================================================
// timer_prescaler : free-running 0..PRESCALE counter producing a one-cycle tick
// Revision: 1.0
// ============================================================================
module timer_prescaler #(
  parameter int PRE_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [PRE_W-1:0] prescale,
  output logic             tick
);

  logic [PRE_W-1:0] presc_cnt;

  assign tick = en && (presc_cnt == prescale);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt <= '0;
    end else if (!en || clr || tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/timer_irq_gen.sv
`default_nettype none
// ============================================================================
// timer_irq_gen : memory-mapped compare timer with sticky W1C level interrupt
// Revision: 1.0
// ============================================================================
module timer_irq_gen
  import timer_irq_gen_pkg::*;
#(
  parameter int INT_ID = INT_TIMER0,
  parameter int CNT_W  = 32,
  parameter int PRE_W  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic [31:0] int_req_o
);

  ctrl_t            ctrl;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] compare;
  logic [PRE_W-1:0] prescale;
  logic [31:0]      rd_mux;

  logic wr;
  logic wr_ctrl;
  logic wr_count;
  logic wr_cmp;
  logic wr_pre;
  logic tick;
  logic match;
  logic hit;
  logic unused_addr;

  assign wr       = req_i && we_i;
  assign wr_ctrl  = wr && (addr_i[3:2] == TIMER_CTRL);
  assign wr_count = wr && (addr_i[3:2] == TIMER_COUNT);
  assign wr_cmp   = wr && (addr_i[3:2] == TIMER_CMP);
  assign wr_pre   = wr && (addr_i[3:2] == TIMER_PRE);
  assign match    = (count == compare);
  assign hit      = tick && match;

  assign unused_addr = ^{addr_i[31:4], addr_i[1:0]};

  timer_prescaler #(
    .PRE_W(PRE_W)
  ) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (ctrl.en),
    .clr     (wr_count || wr_pre),
    .prescale(prescale),
    .tick    (tick)
  );

  // Hardware events are applied after software writes so they win collisions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl <= '0;
    end else begin
      if (wr_ctrl) begin
        ctrl.en          <= wdata_i[CTRL_EN];
        ctrl.int_en      <= wdata_i[CTRL_INT_EN];
        ctrl.auto_reload <= wdata_i[CTRL_AUTO_RELOAD];
      end
      if (hit && !ctrl.auto_reload) begin
        ctrl.en <= 1'b0;
      end
      if (hit) begin
        ctrl.pending <= 1'b1;
      end else if (wr_ctrl && wdata_i[CTRL_PENDING]) begin
        ctrl.pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      compare  <= '0;
      prescale <= '0;
    end else begin
      if (wr_count) begin
        count <= wdata_i[CNT_W-1:0];
      end else if (tick) begin
        if (!match) begin
          count <= count + 1'b1;
        end else if (ctrl.auto_reload) begin
          count <= '0;
        end
      end
      if (wr_cmp) begin
        compare <= wdata_i[CNT_W-1:0];
      end
      if (wr_pre) begin
        prescale <= wdata_i[PRE_W-1:0];
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (addr_i[3:2])
      TIMER_CTRL:  rd_mux[3:0]       = ctrl;
      TIMER_COUNT: rd_mux[CNT_W-1:0] = count;
      TIMER_CMP:   rd_mux[CNT_W-1:0] = compare;
      default:     rd_mux[PRE_W-1:0] = prescale;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_o   <= 1'b0;
      rdata_o <= '0;
    end else begin
      ack_o   <= req_i;
      rdata_o <= (req_i && !we_i) ? rd_mux : 32'h0;
    end
  end

  assign int_req_o = (ctrl.pending && ctrl.int_en) ? (32'h1 << INT_ID) : INT_NONE;

endmodule
`default_nettype wire
